// File: rtl/ps2_arrow_keys_pkg.sv
// Shared constants for the PS/2 arrow-key decoder: arrow bit positions
// (same encoding the car controller uses) and the scancodes of interest.
package ps2_arrow_keys_pkg;

    localparam int unsigned KeyUp    = 0;
    localparam int unsigned KeyDown  = 1;
    localparam int unsigned KeyLeft  = 2;
    localparam int unsigned KeyRight = 3;

    localparam logic [7:0] ScExt   = 8'hE0;
    localparam logic [7:0] ScBrk   = 8'hF0;
    localparam logic [7:0] ScUp    = 8'h75;
    localparam logic [7:0] ScDown  = 8'h72;
    localparam logic [7:0] ScLeft  = 8'h6B;
    localparam logic [7:0] ScRight = 8'h74;

    typedef enum logic [1:0] {
        StIdle,
        StExt,
        StBrk,
        StExtBrk
    } dec_state_e;

    // One-hot arrow mask for a scancode; zero for anything that is not an arrow.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] mask;
        mask = '0;
        case (code)
            ScUp:    mask[KeyUp]    = 1'b1;
            ScDown:  mask[KeyDown]  = 1'b1;
            ScLeft:  mask[KeyLeft]  = 1'b1;
            ScRight: mask[KeyRight] = 1'b1;
            default: mask = '0;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronizes the keyboard lines, debounces the clock,
// deserializes 11-bit frames and abandons frames that stall.
module ps2_rx #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FiltW-1:0] FiltLast = FiltW'(FILTER_LEN - 1);
    localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);

    logic [1:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_s;
    logic             data_s;
    logic             filt_q;
    logic [FiltW-1:0] filt_cnt_q;
    logic             fall;
    logic [3:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [TmoW-1:0]  tmo_q;

    // Two-flop synchronizers on both keyboard lines, idle-high
    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    // High this cycle exactly when the filtered clock is about to drop 1->0
    assign fall = filt_q && !clk_s && (filt_cnt_q == FiltLast);

    // Clock filter: flip only after FILTER_LEN consecutive samples at the new level
    always_ff @(posedge pclk) begin
        if (rst) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else if (clk_s != filt_q) begin
            if (filt_cnt_q == FiltLast) begin
                filt_q     <= clk_s;
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + 1'b1;
            end
        end else begin
            filt_cnt_q <= '0;
        end
    end

    // Deserializer with stall timeout; byte_valid/frame_err are one-cycle pulses
    always_ff @(posedge pclk) begin
        if (rst) begin
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'd0;
            parity_q   <= 1'b0;
            tmo_q      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                tmo_q <= '0;
                if (bit_cnt_q == 4'd0) begin
                    // A high start bit is line noise, not a frame
                    if (!data_s) bit_cnt_q <= 4'd1;
                end else if (bit_cnt_q <= 4'd8) begin
                    shift_q   <= {data_s, shift_q[7:1]};
                    bit_cnt_q <= bit_cnt_q + 4'd1;
                end else if (bit_cnt_q == 4'd9) begin
                    parity_q  <= data_s;
                    bit_cnt_q <= 4'd10;
                end else begin
                    if ((^{shift_q, parity_q}) && data_s) byte_valid <= 1'b1;
                    else                                  frame_err  <= 1'b1;
                    bit_cnt_q <= 4'd0;
                end
            end else if (bit_cnt_q != 4'd0) begin
                if (tmo_q == TmoLast) begin
                    bit_cnt_q <= 4'd0;
                    tmo_q     <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end else begin
                tmo_q <= '0;
            end
        end
    end

    assign data_byte = shift_q;

endmodule

// File: rtl/ps2_arrow_keys.sv
// Arrow-key tracker: decodes extended make/break scancodes from a PS/2
// keyboard into a held up/down/left/right state vector.
module ps2_arrow_keys
    import ps2_arrow_keys_pkg::*;
#(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [3:0] key,
    output logic       frame_err
);
    logic [7:0] rx_byte;
    logic       byte_valid;
    logic [3:0] code_mask;
    dec_state_e state_q;

    ps2_rx #(
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .pclk      (pclk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_byte (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign code_mask = arrow_mask(rx_byte);

    // Scancode decoder; only advances on a good byte, key is registered here
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= StIdle;
            key     <= 4'b0000;
        end else if (byte_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (rx_byte == ScExt)      state_q <= StExt;
                    else if (rx_byte == ScBrk) state_q <= StBrk;
                    else                       state_q <= StIdle;
                end
                StExt: begin
                    if (rx_byte == ScBrk) begin
                        state_q <= StExtBrk;
                    end else if (rx_byte == ScExt) begin
                        state_q <= StExt;
                    end else begin
                        key     <= key | code_mask;
                        state_q <= StIdle;
                    end
                end
                StExtBrk: begin
                    key     <= key & ~code_mask;
                    state_q <= StIdle;
                end
                StBrk: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/ps2_arrow_keys.md
PS2_ARROW_KEYS -- requirements
Module: ps2_arrow_keys

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive equal pclk samples required to change the filtered PS/2 clock level.
REQ-002 Parameter TIMEOUT_CYCLES, default 65000: idle pclk cycles after which a partial frame is abandoned.
REQ-003 pclk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ps2_clk  input  1  keyboard clock, asynchronous to pclk.
REQ-006 ps2_data  input  1  keyboard data, asynchronous to pclk.
REQ-007 key  output  4  held arrow state: bit0 up, bit1 down, bit2 left, bit3 right; 1 = pressed.
REQ-008 frame_err  output  1  one-cycle pulse on a parity or stop-bit error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before use.
REQ-010 Filtered clock SHALL change level only after FILTER_LEN consecutive synchronized samples at the new level; it resets to 1.
REQ-011 A falling edge SHALL be the cycle in which the filtered clock goes 1->0; synchronized ps2_data is sampled in that cycle.
REQ-012 Frame: 11 bits, start(0), 8 data LSB first, odd parity, stop(1); bit counter 0..10.
REQ-013 Start bit sampled as 1 -> ignored; counter stays 0.
REQ-014 After stop bit: byte valid iff parity odd over data+parity and stop = 1; a valid byte SHALL raise internal byte_valid for exactly the next cycle.
REQ-015 Parity or stop error -> byte discarded, frame_err pulses 1 cycle (same cycle byte_valid would have), counter to 0.
REQ-016 Counter nonzero and no falling edge for TIMEOUT_CYCLES cycles -> counter to 0, no frame_err, no byte.
REQ-017 Decoder FSM states IDLE, EXT, BRK, EXT_BRK; evaluated only on byte_valid.
REQ-018 IDLE: E0 -> EXT; F0 -> BRK; any other -> IDLE (non-extended keys ignored, incl. keypad 75/72/6B/74).
REQ-019 EXT: F0 -> EXT_BRK; 75/72/6B/74 -> set up/down/left/right bit, -> IDLE; E0 -> EXT; other -> IDLE.
REQ-020 EXT_BRK: 75/72/6B/74 -> clear the matching bit, -> IDLE; other -> IDLE.
REQ-021 BRK: any byte -> IDLE, key unchanged.
REQ-022 key SHALL update in the cycle after byte_valid; total latency: stop-bit falling edge +2 pclk cycles.
REQ-023 Multiple bits MAY be set simultaneously (including up+down); no arbitration; repeated make codes leave the bit set.
REQ-024 frame_err or timeout SHALL NOT alter FSM state or key.

Reset
REQ-025 During rst: key = 0000, frame_err = 0, FSM = IDLE, bit counter = 0, timeout counter = 0, filtered clock = 1, synchronizers = 1.
REQ-026 rst mid-frame SHALL discard the partial frame; the first falling edge after release is treated as a start bit.

Structure
REQ-027 Shared package: arrow bit indices (UP=0, DOWN=1, LEFT=2, RIGHT=3), matching the car controller key encoding, and scancode constants E0, F0, 75, 72, 6B, 74.
REQ-028 Sub-module ps2_rx (synchronizers, filter, deserializer, timeout, byte/byte_valid/frame_err); ps2_arrow_keys holds the decoder FSM and key register.

Verification
REQ-029 Bench parameters: FILTER_LEN=4, TIMEOUT_CYCLES=2000; PS/2 half-period 40 pclk cycles.
REQ-030 Send E0,75 -> key=0001 two cycles after the last stop-bit falling edge; then E0,F0,75 -> key=0000.
REQ-031 Send E0,6B then E0,75 -> key=0101; then E0,F0,6B -> key=0001.
REQ-032 Send 75 (no E0) then F0,75 -> key stays 0000, FSM back in IDLE.
REQ-033 Send E0 with bad parity, then 74 -> frame_err one 1-cycle pulse; key stays 0000 (74 seen in IDLE).
REQ-034 Send 5 bits, idle 2000+ cycles, then E0,72 -> key=0010 with no frame_err; repeat with rst asserted mid-frame -> same result after release.
REQ-035 Ps2_clk glitch of 2 pclk cycles mid-frame -> no extra bit sampled; the frame still decodes correctly.
